// File: rtl/avalon_cfg_arbiter.sv
// avalon_cfg_arbiter: round-robin sharing of one Avalon-MM register master among N_REQ clients,
// with per-client lock for atomic sequences and a watchdog on stalled transactions.
module avalon_cfg_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_wr,
  input  logic [N_REQ-1:0]          req_rd,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_adr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_done,
  output logic [N_REQ-1:0]          req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      m_wr_rq,
  output logic                      m_rd_rq,
  output logic [ADDR_W-1:0]         m_wr_adr,
  output logic [ADDR_W-1:0]         m_rd_adr,
  output logic [DATA_W-1:0]         m_wr_data,
  input  logic [DATA_W-1:0]         m_rd_data,
  input  logic                      m_action_done
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_DONE, RELEASE, HOLD} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, pick, sel;
  logic [CW-1:0] cnt, cnt_n;
  logic found, issue, wr, fin;
  logic [N_REQ-1:0] grant_n, done_n, err_n;
  logic [DATA_W-1:0] rdata_n, wdata_n, wdat;
  logic [ADDR_W-1:0] wadr_n, radr_n, adr;
  logic wrq_n, rrq_n;

  // ptr doubles as the owner index while a grant is held
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 1; k <= N_REQ; k++)
      if (!found && (req_wr[(int'(ptr) + k) % N_REQ] || req_rd[(int'(ptr) + k) % N_REQ])) begin
        found = 1'b1;
        pick  = IW'((int'(ptr) + k) % N_REQ);
      end
  end

  assign sel   = (state == HOLD) ? ptr : pick;
  assign wr    = req_wr[sel];
  assign adr   = req_adr[sel*ADDR_W +: ADDR_W];
  assign wdat  = req_wdata[sel*DATA_W +: DATA_W];
  assign issue = (state == IDLE && found) || (state == HOLD && (req_wr[ptr] || req_rd[ptr]));
  assign fin   = state == WAIT_DONE && (m_action_done || cnt == CW'(TIMEOUT - 1));
  assign busy  = state != IDLE;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = grant;
    done_n  = '0;
    err_n   = '0;
    rdata_n = req_rdata;
    wrq_n   = m_wr_rq;
    rrq_n   = m_rd_rq;
    wadr_n  = m_wr_adr;
    radr_n  = m_rd_adr;
    wdata_n = m_wr_data;
    if (issue) begin
      state_n = WAIT_DONE;
      ptr_n   = sel;
      cnt_n   = '0;
      grant_n = N_REQ'(1) << sel;
      wrq_n   = wr;
      rrq_n   = !wr;
      wadr_n  = wr ? adr : '0;
      radr_n  = wr ? '0 : adr;
      wdata_n = wr ? wdat : '0;
    end else if (fin) begin
      state_n = RELEASE;
      done_n  = grant;
      err_n   = m_action_done ? '0 : grant;
      rdata_n = (m_action_done && m_rd_rq) ? m_rd_data : req_rdata;
      wrq_n   = 1'b0;
      rrq_n   = 1'b0;
      wadr_n  = '0;
      radr_n  = '0;
      wdata_n = '0;
    end else if (state == WAIT_DONE) begin
      cnt_n = cnt + 1'b1;
    end else if (state == RELEASE || (state == HOLD && !req_lock[ptr])) begin
      state_n = req_lock[ptr] && state == RELEASE ? HOLD : IDLE;
      grant_n = state_n == HOLD ? grant : '0;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      ptr       <= IW'(N_REQ - 1);
      cnt       <= '0;
      grant     <= '0;
      req_done  <= '0;
      req_err   <= '0;
      req_rdata <= '0;
      m_wr_rq   <= 1'b0;
      m_rd_rq   <= 1'b0;
      m_wr_adr  <= '0;
      m_rd_adr  <= '0;
      m_wr_data <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      grant     <= grant_n;
      req_done  <= done_n;
      req_err   <= err_n;
      req_rdata <= rdata_n;
      m_wr_rq   <= wrq_n;
      m_rd_rq   <= rrq_n;
      m_wr_adr  <= wadr_n;
      m_rd_adr  <= radr_n;
      m_wr_data <= wdata_n;
    end
endmodule
